// File: rtl/instr_fetch_unit.sv
// PC-side fetch engine for the multicycle CPU: owns the program counter, latches
// instructions into the IR and computes the next PC on controller request.
module instr_fetch_unit #(
  parameter logic [31:0] LAST_PC = 32'd35,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [31:0]      imem_pc,
  input  logic [31:0]      imem_instr,
  input  logic             next_pc_en,
  input  logic [1:0]       pc_src,
  input  logic             branch_taken,
  output logic [31:0]      ir,
  output logic             ir_valid,
  output logic [31:0]      pc,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [31:0]      pc_reg;
  logic [31:0]      ir_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [31:0] offset;
  logic [31:0] target;
  logic        target_past_end;

  // Offset is relative to pc_reg+1; the immediate comes from the latched IR,
  // never from the memory bus, which is only meaningful on the FETCH edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    offset = 32'd0;
    unique case (pc_src)
      SRC_BRANCH: if (branch_taken) offset = {{16{ir_reg[15]}}, ir_reg[15:0]};
      SRC_JUMP:   offset = {{6{ir_reg[25]}}, ir_reg[25:0]};
      default:    offset = 32'd0;
    endcase
  end

  assign target          = pc_reg + 32'd1 + offset;
  assign target_past_end = (target > LAST_PC);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc_reg  <= 32'd0;
      ir_reg  <= 32'd0;
      cnt_reg <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state   <= S_FETCH;
            pc_reg  <= 32'd0;
            cnt_reg <= '0;
          end
        end
        S_FETCH: begin
          ir_reg <= imem_instr;
          if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_ONE;
          state  <= S_DECODE;
        end
        S_DECODE: begin
          // start is deliberately not looked at here: a PC request wins.
          if (next_pc_en) begin
            pc_reg <= target;
            state  <= target_past_end ? S_HALT : S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_pc     = pc_reg;
  assign pc          = pc_reg;
  assign ir          = ir_reg;
  assign fetch_count = cnt_reg;
  assign ir_valid    = (state == S_DECODE);
  assign halted      = (state == S_HALT);

endmodule
